// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_light_monitor
//  Purpose  : Passive safety monitor for a two-road junction controller.
//             Decodes the six lamp outputs into a phase every clock, flags
//             illegal lamp vectors, out-of-order phases and phases that end
//             too early. It also reports the dwell time of the current phase
//             and counts completed light cycles. It never drives any lamp.
//  Ports    : Clk, reset        clock (rising edge), synchronous active-high reset
//             MR MY MG SR SY SG lamp outputs sampled from the controller
//             C                 side-road car sensor
//             clr               clears the sticky err_any flag
//             phase[2:0]        0 UNSYNC, 1 MAIN_GREEN, 2 MAIN_YELLOW,
//                               3 SIDE_GREEN, 4 SIDE_YELLOW
//             dwell[15:0]       samples spent in the current phase (saturating)
//             cycle_count[15:0] completed SIDE_YELLOW->MAIN_GREEN transitions
//             err_illegal/err_seq/err_short/err_starve  one-cycle pulses
//             err_any           sticky OR of all error pulses
//  Options  : TLMON_STARVE_EN   builds the side-road starvation checker;
//                               without it err_starve is tied to 0.
//  Revision : 1.0  initial release
// ============================================================================
module traffic_light_monitor #(
    parameter int MIN_GREEN  = 15,
    parameter int MIN_YELLOW = 5,
    parameter int MAX_WAIT   = 64
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        MR,
    input  logic        MY,
    input  logic        MG,
    input  logic        SR,
    input  logic        SY,
    input  logic        SG,
    input  logic        C,
    input  logic        clr,
    output logic [2:0]  phase,
    output logic [15:0] dwell,
    output logic [15:0] cycle_count,
    output logic        err_illegal,
    output logic        err_seq,
    output logic        err_short,
    output logic        err_starve,
    output logic        err_any
);

    typedef enum logic [2:0] {
        S_UNSYNC      = 3'd0,
        S_MAIN_GREEN  = 3'd1,
        S_MAIN_YELLOW = 3'd2,
        S_SIDE_GREEN  = 3'd3,
        S_SIDE_YELLOW = 3'd4
    } state_t;

    localparam logic [15:0] c_min_green  = 16'(MIN_GREEN);
    localparam logic [15:0] c_min_yellow = 16'(MIN_YELLOW);
    localparam logic [15:0] c_dwell_max  = 16'hFFFF;

    state_t      r_state;
    state_t      w_vec_state;
    state_t      w_succ;
    logic        w_illegal;
    logic        w_same;
    logic        w_advance;
    logic        w_skip;
    logic [15:0] w_min;
    logic        w_short;
    logic        w_cycle;
    logic        w_starve;
    logic        w_any;

    // Lamp vector -> phase; anything not in the table (incl. all-off) is illegal.
    always_comb begin
        w_vec_state = S_UNSYNC;
        case ({MR, MY, MG, SR, SY, SG})
            6'b001100: w_vec_state = S_MAIN_GREEN;
            6'b010100: w_vec_state = S_MAIN_YELLOW;
            6'b100001: w_vec_state = S_SIDE_GREEN;
            6'b100010: w_vec_state = S_SIDE_YELLOW;
            default:   w_vec_state = S_UNSYNC;
        endcase
    end

    // Legal successor of the current phase; UNSYNC has none.
    always_comb begin
        w_succ = S_UNSYNC;
        case (r_state)
            S_MAIN_GREEN:  w_succ = S_MAIN_YELLOW;
            S_MAIN_YELLOW: w_succ = S_SIDE_GREEN;
            S_SIDE_GREEN:  w_succ = S_SIDE_YELLOW;
            S_SIDE_YELLOW: w_succ = S_MAIN_GREEN;
            default:       w_succ = S_UNSYNC;
        endcase
    end

    assign w_illegal = (w_vec_state == S_UNSYNC);
    assign w_same    = !w_illegal && (w_vec_state == r_state);
    // From UNSYNC w_succ is UNSYNC, which a legal vector never matches, so
    // the first legal vector after UNSYNC is neither an advance nor a skip.
    assign w_advance = !w_illegal && !w_same && (w_vec_state == w_succ);
    assign w_skip    = !w_illegal && !w_same && (r_state != S_UNSYNC) && !w_advance;

    assign w_min   = ((r_state == S_MAIN_GREEN) || (r_state == S_SIDE_GREEN))
                     ? c_min_green : c_min_yellow;
    // A saturated dwell is treated as long enough regardless of the minimum.
    assign w_short = w_advance && (dwell != c_dwell_max) && (dwell < w_min);
    assign w_cycle = w_advance && (r_state == S_SIDE_YELLOW);

`ifdef TLMON_STARVE_EN
    localparam logic [15:0] c_max_wait = 16'(MAX_WAIT);

    logic [15:0] r_wait;
    logic [15:0] w_wait_next;

    // Counts C=1 samples belonging to a MAIN_GREEN phase, entry sample
    // included. Holding at MAX_WAIT keeps the pulse to a single cycle.
    always_comb begin
        w_wait_next = '0;
        w_starve    = 1'b0;
        if (w_vec_state == S_MAIN_GREEN) begin
            if (!w_same) begin
                w_wait_next = C ? 16'd1 : 16'd0;
            end else if (C && (r_wait != c_max_wait)) begin
                w_wait_next = r_wait + 16'd1;
            end else begin
                w_wait_next = r_wait;
            end
            w_starve = C && (w_wait_next == c_max_wait)
                       && (!w_same || (r_wait != c_max_wait));
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_wait <= '0;
        end else begin
            r_wait <= w_wait_next;
        end
    end
`else
    logic w_unused_starve;

    assign w_starve        = 1'b0;
    assign w_unused_starve = C ^ (MAX_WAIT != 0);
`endif

    assign w_any = w_illegal || w_skip || w_short || w_starve;

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state     <= S_UNSYNC;
            dwell       <= '0;
            cycle_count <= '0;
            err_illegal <= 1'b0;
            err_seq     <= 1'b0;
            err_short   <= 1'b0;
            err_starve  <= 1'b0;
            err_any     <= 1'b0;
        end else begin
            // Illegal vectors decode to UNSYNC, so the new phase is always the decode.
            r_state <= w_vec_state;
            if (w_same) begin
                if (dwell != c_dwell_max) begin
                    dwell <= dwell + 16'd1;
                end
            end else if (w_illegal) begin
                dwell <= '0;
            end else begin
                dwell <= 16'd1;
            end
            cycle_count <= cycle_count + {15'd0, w_cycle};
            err_illegal <= w_illegal;
            err_seq     <= w_skip;
            err_short   <= w_short;
            err_starve  <= w_starve;
            // A new error outranks a simultaneous clear.
            if (w_any) begin
                err_any <= 1'b1;
            end else if (clr) begin
                err_any <= 1'b0;
            end
        end
    end

    assign phase = r_state;

endmodule
`default_nettype wire
